// File: rtl/motoro3_step_sequencer_if.sv
// Config/status bundle for the motor step sequencer.
// Master drives the m3r_* controls, slave returns the step outputs.
interface motoro3_step_sequencer_if;
    logic        m3r_run;
    logic        m3r_dir;
    logic [24:0] m3r_stepPeriod;
    logic [15:0] m3r_plLenTarget;
    logic [15:0] m3r_plLenStep;
    logic [24:0] m3cnt;
    logic        m3cntLast2;
    logic        m3cntLast1;
    logic [3:0]  sgStep;
    logic [15:0] plLen;
    logic        running;

    modport master (
        output m3r_run, m3r_dir, m3r_stepPeriod,
        output m3r_plLenTarget, m3r_plLenStep,
        input  m3cnt, m3cntLast2, m3cntLast1,
        input  sgStep, plLen, running
    );

    modport slave (
        input  m3r_run, m3r_dir, m3r_stepPeriod,
        input  m3r_plLenTarget, m3r_plLenStep,
        output m3cnt, m3cntLast2, m3cntLast1,
        output sgStep, plLen, running
    );
endinterface

// File: rtl/motoro3_step_sequencer.sv
// Commutation step sequencer with plLen ramping; registers on falling clk.
// Define MOTORO3_STEP_RAMP_EN for stepped ramps, else plLen jumps to target.
module motoro3_step_sequencer (
    input  logic                     clk,
    input  logic                     nRst,
    motoro3_step_sequencer_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_t;

    state_t      state;
    state_t      stateNext;
    logic [24:0] cnt;
    logic [24:0] cntNext;
    logic [3:0]  step;
    logic [3:0]  stepNext;
    logic [15:0] pl;
    logic [15:0] plNext;
    logic [15:0] rampVal;
    logic [24:0] reloadVal;
    logic        active;

    assign active    = (state != IDLE);
    assign reloadVal = (bus.m3r_stepPeriod < 25'd4) ? 25'd3
                     : bus.m3r_stepPeriod - 25'd1;

`ifdef MOTORO3_STEP_RAMP_EN
    logic [16:0] pl17;
    logic [16:0] tgt17;
    logic [16:0] stp17;
    logic [16:0] up17;
    logic [16:0] dn17;

    assign pl17  = {1'b0, pl};
    assign tgt17 = {1'b0, bus.m3r_plLenTarget};
    assign stp17 = {1'b0, bus.m3r_plLenStep};
    assign up17  = pl17 + stp17;
    assign dn17  = pl17 - stp17;

    always_comb begin
        rampVal = pl;
        if (state == RUN) begin
            if (pl17 < tgt17) begin
                rampVal = (up17 > tgt17) ? bus.m3r_plLenTarget : up17[15:0];
            end else if (pl17 > tgt17) begin
                // Compare before subtracting so the floor at target never wraps
                rampVal = (pl17 < tgt17 + stp17) ? bus.m3r_plLenTarget
                        : dn17[15:0];
            end
        end else if (state == STOP) begin
            if ((stp17 == 17'd0) || (pl17 <= stp17)) begin
                rampVal = 16'd0;
            end else begin
                rampVal = dn17[15:0];
            end
        end
    end
`else
    always_comb begin
        rampVal = pl;
        if (state == RUN) begin
            rampVal = bus.m3r_plLenTarget;
        end else if (state == STOP) begin
            rampVal = 16'd0;
        end
    end
`endif

    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        stepNext  = step;
        plNext    = pl;
        unique case (state)
            IDLE: begin
                cntNext  = 25'd0;
                stepNext = 4'd0;
                plNext   = 16'd0;
                if (bus.m3r_run) begin
                    stateNext = RUN;
                    cntNext   = reloadVal;
                end
            end
            RUN, STOP: begin
                stateNext = bus.m3r_run ? RUN : STOP;
                if (cnt != 25'd0) begin
                    cntNext = cnt - 25'd1;
                end else if (state == STOP && !bus.m3r_run && pl == 16'd0) begin
                    stateNext = IDLE;
                    cntNext   = 25'd0;
                    stepNext  = 4'd0;
                end else begin
                    cntNext = reloadVal;
                    plNext  = rampVal;
                    if (bus.m3r_dir) begin
                        stepNext = (step == 4'd0) ? 4'd11 : step - 4'd1;
                    end else begin
                        stepNext = (step == 4'd11) ? 4'd0 : step + 4'd1;
                    end
                end
            end
            default: begin
                stateNext = IDLE;
                cntNext   = 25'd0;
                stepNext  = 4'd0;
                plNext    = 16'd0;
            end
        endcase
    end

    always_ff @(negedge clk) begin
        if (nRst) begin
            state <= IDLE;
            cnt   <= 25'd0;
            step  <= 4'd0;
            pl    <= 16'd0;
        end else begin
            state <= stateNext;
            cnt   <= cntNext;
            step  <= stepNext;
            pl    <= plNext;
        end
    end

    assign bus.m3cnt      = cnt;
    assign bus.m3cntLast2 = active && (cnt == 25'd1);
    assign bus.m3cntLast1 = active && (cnt == 25'd0);
    assign bus.sgStep     = step;
    assign bus.plLen      = pl;
    assign bus.running    = active;
endmodule

// File: tb/tb_motoro3_step_sequencer.sv
// Randomized and directed checks of motoro3_step_sequencer against a
// step-level behavioural model.
module tb_motoro3_step_sequencer;
    logic clk;
    logic nRst;
    int   nChecks;
    int   nFail;

    motoro3_step_sequencer_if bus ();

    motoro3_step_sequencer dut (
        .clk  (clk),
        .nRst (nRst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_STOP = 2;

    int mMode;
    int mCnt;
    int mStep;
    int mPl;

    function automatic int rampNext(int mode, int pl, int tgt, int stp);
`ifdef MOTORO3_STEP_RAMP_EN
        if (mode == M_RUN) begin
            if (pl < tgt) return (pl + stp > tgt) ? tgt : pl + stp;
            if (pl > tgt) return (pl - stp < tgt) ? tgt : pl - stp;
            return pl;
        end
        if (stp == 0) return 0;
        return (pl - stp < 0) ? 0 : pl - stp;
`else
        return (mode == M_RUN) ? tgt : 0;
`endif
    endfunction

    task automatic modelEdge();
        int eff;
        eff = (bus.m3r_stepPeriod < 4) ? 4 : int'(bus.m3r_stepPeriod);
        if (nRst) begin
            mMode = M_IDLE; mCnt = 0; mStep = 0; mPl = 0;
        end else if (mMode == M_IDLE) begin
            if (bus.m3r_run) begin
                mMode = M_RUN;
                mCnt  = eff - 1;
            end
        end else if (mCnt > 0) begin
            mCnt--;
            mMode = bus.m3r_run ? M_RUN : M_STOP;
        end else if (mMode == M_STOP && !bus.m3r_run && mPl == 0) begin
            mMode = M_IDLE; mCnt = 0; mStep = 0;
        end else begin
            mCnt  = eff - 1;
            mStep = (mStep + (bus.m3r_dir ? 11 : 1)) % 12;
            mPl   = rampNext(mMode, mPl, int'(bus.m3r_plLenTarget),
                             int'(bus.m3r_plLenStep));
            mMode = bus.m3r_run ? M_RUN : M_STOP;
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        modelEdge();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        nRst = 1'b1;
        bus.m3r_run = 1'b0;
        bus.m3r_dir = 1'b0;
        cyc();
        cyc();
        nRst = 1'b0;
    endtask

    task automatic test_reset();
        doReset();
        nChecks++;
        if (bus.m3cnt !== 25'd0 || bus.sgStep !== 4'd0 || bus.plLen !== 16'd0) begin
            nFail++;
            $display("FAIL reset_regs cnt=%0d step=%0d pl=%0d want 0/0/0",
                     bus.m3cnt, bus.sgStep, bus.plLen);
        end
        nChecks++;
        if ({bus.running, bus.m3cntLast1, bus.m3cntLast2} !== 3'b000) begin
            nFail++;
            $display("FAIL reset_flags got %b want 000",
                     {bus.running, bus.m3cntLast1, bus.m3cntLast2});
        end
        cyc();
        nChecks++;
        if (bus.running !== 1'b0 || bus.m3cnt !== 25'd0) begin
            nFail++;
            $display("FAIL idle_hold run=%0b cnt=%0d want 0/0",
                     bus.running, bus.m3cnt);
        end
    endtask

    task automatic test_period10();
        int ec;
        doReset();
        bus.m3r_stepPeriod = 25'd10;
        bus.m3r_run = 1'b1;
        cyc();
        for (int k = 0; k < 130; k++) begin
            ec = 9 - k % 10;
            nChecks++;
            if (bus.m3cnt !== 25'(ec) || bus.sgStep !== 4'((k / 10) % 12)) begin
                nFail++;
                $display("FAIL p10 k=%0d cnt=%0d step=%0d want %0d/%0d",
                         k, bus.m3cnt, bus.sgStep, ec, (k / 10) % 12);
            end
            nChecks++;
            if (bus.m3cntLast2 !== (ec == 1) || bus.m3cntLast1 !== (ec == 0)) begin
                nFail++;
                $display("FAIL p10_last k=%0d l2=%0b l1=%0b want %0b/%0b",
                         k, bus.m3cntLast2, bus.m3cntLast1, ec == 1, ec == 0);
            end
            cyc();
        end
    endtask

    task automatic test_min_period();
        doReset();
        bus.m3r_stepPeriod = 25'd2;
        bus.m3r_run = 1'b1;
        cyc();
        for (int k = 0; k < 12; k++) begin
            nChecks++;
            if (bus.m3cnt !== 25'(3 - k % 4) || bus.sgStep !== 4'(k / 4)) begin
                nFail++;
                $display("FAIL minp k=%0d cnt=%0d step=%0d want %0d/%0d",
                         k, bus.m3cnt, bus.sgStep, 3 - k % 4, k / 4);
            end
            cyc();
        end
    endtask

    task automatic test_dir_down();
        int es;
        doReset();
        bus.m3r_stepPeriod = 25'd5;
        bus.m3r_dir = 1'b1;
        bus.m3r_run = 1'b1;
        cyc();
        for (int k = 0; k < 30; k++) begin
            es = (12 - (k / 5) % 12) % 12;
            nChecks++;
            if (bus.sgStep !== 4'(es) || bus.m3cnt !== 25'(4 - k % 5)) begin
                nFail++;
                $display("FAIL down k=%0d step=%0d cnt=%0d want %0d/%0d",
                         k, bus.sgStep, bus.m3cnt, es, 4 - k % 5);
            end
            cyc();
        end
    endtask

    task automatic test_dir_mid();
        doReset();
        bus.m3r_stepPeriod = 25'd6;
        bus.m3r_run = 1'b1;
        cyc();
        repeat (8) cyc();
        bus.m3r_dir = 1'b1;
        for (int k = 8; k < 12; k++) begin
            nChecks++;
            if (bus.sgStep !== 4'd1) begin
                nFail++;
                $display("FAIL dirmid_hold k=%0d step=%0d want 1", k, bus.sgStep);
            end
            cyc();
        end
        nChecks++;
        if (bus.sgStep !== 4'd0) begin
            nFail++;
            $display("FAIL dirmid_flip step=%0d want 0", bus.sgStep);
        end
        repeat (6) cyc();
        nChecks++;
        if (bus.sgStep !== 4'd11) begin
            nFail++;
            $display("FAIL dirmid_wrap step=%0d want 11", bus.sgStep);
        end
    endtask

`ifdef MOTORO3_STEP_RAMP_EN
    task automatic test_ramp();
        int exp [7] = '{30, 60, 90, 100, 100, 70, 50};
        doReset();
        bus.m3r_stepPeriod  = 25'd4;
        bus.m3r_plLenTarget = 16'd100;
        bus.m3r_plLenStep   = 16'd30;
        bus.m3r_run = 1'b1;
        cyc();
        for (int i = 0; i < 7; i++) begin
            if (i == 5) bus.m3r_plLenTarget = 16'd50;
            repeat (4) cyc();
            nChecks++;
            if (bus.plLen !== 16'(exp[i])) begin
                nFail++;
                $display("FAIL ramp i=%0d pl=%0d want %0d", i, bus.plLen, exp[i]);
            end
        end
    endtask

    task automatic test_stop();
        int exp [4] = '{70, 40, 10, 0};
        doReset();
        bus.m3r_stepPeriod  = 25'd4;
        bus.m3r_plLenTarget = 16'd100;
        bus.m3r_plLenStep   = 16'd30;
        bus.m3r_run = 1'b1;
        cyc();
        repeat (16) cyc();
        bus.m3r_run = 1'b0;
        for (int i = 0; i < 4; i++) begin
            repeat (4) cyc();
            nChecks++;
            if (bus.plLen !== 16'(exp[i]) || bus.running !== 1'b1) begin
                nFail++;
                $display("FAIL stop i=%0d pl=%0d run=%0b want %0d/1",
                         i, bus.plLen, bus.running, exp[i]);
            end
        end
        repeat (4) cyc();
        nChecks++;
        if (bus.running !== 1'b0 || bus.m3cnt !== 25'd0) begin
            nFail++;
            $display("FAIL stop_idle run=%0b cnt=%0d want 0/0",
                     bus.running, bus.m3cnt);
        end
        bus.m3r_run = 1'b1;
        cyc();
        repeat (16) cyc();
        bus.m3r_run = 1'b0;
        repeat (4) cyc();
        bus.m3r_run = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cyc();
            nChecks++;
            if (bus.running !== 1'b1) begin
                nFail++;
                $display("FAIL restart_run k=%0d run=%0b want 1", k, bus.running);
            end
        end
        nChecks++;
        if (bus.plLen !== 16'd100) begin
            nFail++;
            $display("FAIL restart_pl pl=%0d want 100", bus.plLen);
        end
    endtask
`else
    task automatic test_noramp();
        doReset();
        bus.m3r_stepPeriod  = 25'd4;
        bus.m3r_plLenTarget = 16'd123;
        bus.m3r_plLenStep   = 16'd7;
        bus.m3r_run = 1'b1;
        cyc();
        nChecks++;
        if (bus.plLen !== 16'd0) begin
            nFail++;
            $display("FAIL noramp_first pl=%0d want 0", bus.plLen);
        end
        repeat (4) cyc();
        nChecks++;
        if (bus.plLen !== 16'd123) begin
            nFail++;
            $display("FAIL noramp_jump pl=%0d want 123", bus.plLen);
        end
        bus.m3r_run = 1'b0;
        repeat (4) cyc();
        nChecks++;
        if (bus.plLen !== 16'd0 || bus.running !== 1'b1) begin
            nFail++;
            $display("FAIL noramp_stop pl=%0d run=%0b want 0/1",
                     bus.plLen, bus.running);
        end
        repeat (4) cyc();
        nChecks++;
        if (bus.running !== 1'b0) begin
            nFail++;
            $display("FAIL noramp_idle run=%0b want 0", bus.running);
        end
    endtask
`endif

    task automatic test_reset_mid();
        doReset();
        bus.m3r_stepPeriod  = 25'd10;
        bus.m3r_plLenTarget = 16'd500;
        bus.m3r_plLenStep   = 16'd40;
        bus.m3r_run = 1'b1;
        cyc();
        repeat (74) cyc();
        nChecks++;
        if (bus.m3cnt !== 25'd5 || bus.sgStep !== 4'd7 || bus.plLen === 16'd0) begin
            nFail++;
            $display("FAIL pre_reset cnt=%0d step=%0d pl=%0d want 5/7/nonzero",
                     bus.m3cnt, bus.sgStep, bus.plLen);
        end
        nRst = 1'b1;
        cyc();
        nChecks++;
        if (bus.m3cnt !== 25'd0 || bus.sgStep !== 4'd0 || bus.plLen !== 16'd0 ||
            {bus.running, bus.m3cntLast1, bus.m3cntLast2} !== 3'b000) begin
            nFail++;
            $display("FAIL mid_reset cnt=%0d step=%0d pl=%0d flags=%b want all 0",
                     bus.m3cnt, bus.sgStep, bus.plLen,
                     {bus.running, bus.m3cntLast1, bus.m3cntLast2});
        end
        nRst = 1'b0;
    endtask

    task automatic test_random();
        doReset();
        bus.m3r_run = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom % 40 == 0) bus.m3r_run = ~bus.m3r_run;
            if ($urandom % 15 == 0) bus.m3r_dir = 1'($urandom);
            if ($urandom % 10 == 0) bus.m3r_stepPeriod = 25'($urandom_range(0, 9));
            if ($urandom % 25 == 0)
                bus.m3r_plLenTarget = ($urandom % 4 == 0)
                    ? 16'(65535 - $urandom_range(0, 100))
                    : 16'($urandom_range(0, 400));
            if ($urandom % 25 == 0)
                bus.m3r_plLenStep = ($urandom % 5 == 0) ? 16'($urandom % 2 * 65535)
                    : 16'($urandom_range(0, 120));
            nRst = ($urandom % 400 == 0);
            cyc();
            nChecks++;
            if (bus.m3cnt !== 25'(mCnt) || bus.sgStep !== 4'(mStep) ||
                bus.plLen !== 16'(mPl)) begin
                nFail++;
                $display("FAIL rand_regs k=%0d cnt=%0d step=%0d pl=%0d want %0d/%0d/%0d",
                         k, bus.m3cnt, bus.sgStep, bus.plLen, mCnt, mStep, mPl);
            end
            nChecks++;
            if (bus.running !== (mMode != M_IDLE) ||
                bus.m3cntLast2 !== (mMode != M_IDLE && mCnt == 1) ||
                bus.m3cntLast1 !== (mMode != M_IDLE && mCnt == 0)) begin
                nFail++;
                $display("FAIL rand_flags k=%0d run=%0b l2=%0b l1=%0b mode=%0d cnt=%0d",
                         k, bus.running, bus.m3cntLast2, bus.m3cntLast1, mMode, mCnt);
            end
        end
        nRst = 1'b0;
    endtask

    initial begin
        nChecks = 0;
        nFail   = 0;
        mMode = M_IDLE; mCnt = 0; mStep = 0; mPl = 0;
        nRst = 1'b1;
        bus.m3r_run         = 1'b0;
        bus.m3r_dir         = 1'b0;
        bus.m3r_stepPeriod  = 25'd10;
        bus.m3r_plLenTarget = 16'd0;
        bus.m3r_plLenStep   = 16'd0;
        test_reset();
        test_period10();
        test_min_period();
        test_dir_down();
        test_dir_mid();
`ifdef MOTORO3_STEP_RAMP_EN
        test_ramp();
        test_stop();
`else
        test_noramp();
`endif
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 nChecks, nFail);
        $finish;
    end
endmodule
